// File: rtl/bk_adder_16b_reg.sv
// 16-bit Brent-Kung parallel-prefix adder with a registered 17-bit result.
// The prefix network is written out cell by cell so the tree shape
// (up-sweep levels 1-4, down-sweep A/B/C) is visible and fixed in the netlist.
module bk_adder_16b_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  output logic [16:0] out0
);

  // Bitwise generate / propagate
  logic [15:0] w_g;
  logic [15:0] w_p;

  // Up-sweep group signals; index k covers span [W*k+W-1 : W*k].
  // Group P is omitted for spans ending at bit 0 (gray cells need only G).
  logic [7:0]  w_g1;
  logic [7:1]  w_p1;
  logic [3:0]  w_g2;
  logic [3:1]  w_p2;
  logic [1:0]  w_g3;
  logic        w_p3;
  logic        w_g4;

  // w_c[i] = carry into bit i = G[i-1:0]
  logic [16:0] w_c;
  logic [15:0] w_sum;
  logic [16:0] r_out0;

  assign w_g = in0 & in1;
  assign w_p = in0 ^ in1;

  // Up-sweep level 1: [2k+1:2k]
  for (genvar k = 0; k < 8; k++) begin : g_lvl1
    assign w_g1[k] = w_g[2*k+1] | (w_p[2*k+1] & w_g[2*k]);
    if (k > 0) begin : g_p
      assign w_p1[k] = w_p[2*k+1] & w_p[2*k];
    end
  end

  // Up-sweep level 2: [4k+3:4k]
  for (genvar k = 0; k < 4; k++) begin : g_lvl2
    assign w_g2[k] = w_g1[2*k+1] | (w_p1[2*k+1] & w_g1[2*k]);
    if (k > 0) begin : g_p
      assign w_p2[k] = w_p1[2*k+1] & w_p1[2*k];
    end
  end

  // Up-sweep level 3: [7:0], [15:8]
  assign w_g3[0] = w_g2[1] | (w_p2[1] & w_g2[0]);
  assign w_g3[1] = w_g2[3] | (w_p2[3] & w_g2[2]);
  assign w_p3    = w_p2[3] & w_p2[2];

  // Up-sweep level 4: [15:0]
  assign w_g4 = w_g3[1] | (w_p3 & w_g3[0]);

  // Carries available straight from the up-sweep
  assign w_c[0]  = 1'b0;
  assign w_c[1]  = w_g[0];
  assign w_c[2]  = w_g1[0];
  assign w_c[4]  = w_g2[0];
  assign w_c[8]  = w_g3[0];
  assign w_c[16] = w_g4;

  // Down-sweep A: [11:0] = [11:8] o [7:0]
  assign w_c[12] = w_g2[2] | (w_p2[2] & w_c[8]);

  // Down-sweep B: [5:0], [9:0], [13:0]
  assign w_c[6]  = w_g1[2] | (w_p1[2] & w_c[4]);
  assign w_c[10] = w_g1[4] | (w_p1[4] & w_c[8]);
  assign w_c[14] = w_g1[6] | (w_p1[6] & w_c[12]);

  // Down-sweep C: [2k:0] = [2k:2k] o [2k-1:0] for k = 1..7
  for (genvar k = 1; k < 8; k++) begin : g_dnc
    assign w_c[2*k+1] = w_g[2*k] | (w_p[2*k] & w_c[2*k]);
  end

  assign w_sum = w_p ^ w_c[15:0];

  // Output register: async clear, captures sum and carry-out every edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out0 <= 17'h0;
    else     r_out0 <= {w_c[16], w_sum};
  end

  assign out0 = r_out0;

endmodule

// File: tb/tb_bk_adder_16b_reg.sv
// Self-checking bench for bk_adder_16b_reg: directed corner cases, async
// reset behaviour, and random operands against an arithmetic reference.
module tb_bk_adder_16b_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in0;
  logic [15:0] in1;
  logic [16:0] out0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q = 17'h0;

  bk_adder_16b_reg dut (
    .clk  (clk),
    .rst  (rst),
    .in0  (in0),
    .in1  (in1),
    .out0 (out0)
  );

  always #5 clk = ~clk;

  // Reference: exact 17-bit unsigned sum
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    s = int'(a) + int'(b);
    return s[16:0];
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // One operand pair per cycle: the previous result must still hold before the
  // edge, and the new sum must appear right after it.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk({tag, "_hold"}, out0, exp_q);
    in0 = a;
    in1 = b;
    @(posedge clk);
    #1;
    exp_q = ref_add(a, b);
    chk(tag, out0, exp_q);
  endtask

  initial begin
    rst = 1'b1;
    in0 = 16'h1234;
    in1 = 16'h4321;
    #1;
    chk("reset_async", out0, 17'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_held", out0, 17'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_no_edge", out0, 17'h0);
    @(posedge clk);
    #1;
    exp_q = 17'h05555;
    chk("first_after_reset", out0, exp_q);

    step("ffff_1",      16'hFFFF, 16'h0001);
    chk("ffff_1_const", out0, 17'h10000);
    step("8000_8000",   16'h8000, 16'h8000);
    step("ffff_ffff",   16'hFFFF, 16'hFFFF);
    chk("max_const",    out0, 17'h1FFFE);
    step("zero_zero",   16'h0000, 16'h0000);
    step("b2b_00ff",    16'h00FF, 16'h0001);
    step("b2b_7fff",    16'h7FFF, 16'h0001);
    step("b2b_aaaa",    16'hAAAA, 16'h5555);
    chk("b2b_aaaa_const", out0, 17'h0FFFF);

    // Async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_drop", out0, 17'h0);
    exp_q = 17'h0;
    in0 = 16'h1111;
    in1 = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("async_hold", out0, 17'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q = 17'h03333;
    chk("post_async_release", out0, exp_q);

    // Single-bit operand against a low-ones mask
    for (int k = 0; k < 16; k++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'h1 << k;
      b = 16'hFFFF >> (15 - k);
      step("bit_mask", a, b);
    end

    // Random operands
    for (int i = 0; i < 3000; i++) begin
      step("random", 16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
